// File: rtl/axis_output_pipe.sv
// Egress pipe: buffers one engine beat of ROWS words and streams it out as W_OUT-word AXI-Stream chunks.
// Optional statistics ports and counters are enabled by defining AXIS_OUTPUT_PIPE_STATS_EN.
module axis_output_pipe #(
   parameter int ROWS              = 8,
   parameter int WORD_WIDTH_OUT    = 32,
   parameter int M_OUTPUT_WIDTH_LF = 96
) (
   input  logic                                          aclk,
   input  logic                                          areset,
   output logic                                          s_axis_tready,
   input  logic                                          s_axis_tvalid,
   input  logic                                          s_axis_tlast,
   input  logic [ROWS*WORD_WIDTH_OUT-1:0]                s_axis_tdata,
   input  logic                                          m_axis_tready,
   output logic                                          m_axis_tvalid,
   output logic                                          m_axis_tlast,
   output logic [M_OUTPUT_WIDTH_LF-1:0]                  m_axis_tdata,
   output logic [M_OUTPUT_WIDTH_LF/WORD_WIDTH_OUT-1:0]   m_axis_tkeep
`ifdef AXIS_OUTPUT_PIPE_STATS_EN
   ,
   output logic [31:0]                                   m_stat_packets,
   output logic [31:0]                                   m_stat_stalls
`endif
);

   localparam int W_OUT      = M_OUTPUT_WIDTH_LF / WORD_WIDTH_OUT;
   localparam int NUM_CHUNKS = (ROWS + W_OUT - 1) / W_OUT;
   localparam int LAST_WORDS = ROWS - (NUM_CHUNKS - 1) * W_OUT;
   localparam int CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam int DATA_W     = ROWS * WORD_WIDTH_OUT;
   localparam int PAD_W      = NUM_CHUNKS * M_OUTPUT_WIDTH_LF;

   localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);
   localparam logic [W_OUT-1:0]   FULL_KEEP  = {W_OUT{1'b1}};
   localparam logic [W_OUT-1:0]   LAST_KEEP  = FULL_KEEP >> (W_OUT - LAST_WORDS);

   typedef enum logic {
      EMPTY = 1'b0,
      SEND  = 1'b1
   } state_t;

   state_t               state;
   logic [CHUNK_W-1:0]   chunk;
   logic [DATA_W-1:0]    buf_data;
   logic                 buf_last;
   logic                 full;
   logic                 last_chunk;
   logic                 load;
   logic                 out_hs;
   logic [PAD_W-1:0]     padded_data;

   assign full          = (state == SEND);
   assign last_chunk    = (chunk == LAST_CHUNK);
   assign s_axis_tready = !areset && (!full || (m_axis_tready && last_chunk));
   assign load          = s_axis_tvalid && s_axis_tready;
   assign out_hs        = full && m_axis_tready;

   // Zero-extend the buffer to a whole number of chunks so the tail chunk reads zeros past ROWS.
   always_comb begin
      padded_data             = '0;
      padded_data[DATA_W-1:0] = buf_data;
   end

   assign m_axis_tvalid = full;
   assign m_axis_tlast  = full && buf_last && last_chunk;
   assign m_axis_tdata  = full ? padded_data[chunk*M_OUTPUT_WIDTH_LF +: M_OUTPUT_WIDTH_LF] : '0;
   assign m_axis_tkeep  = full ? (last_chunk ? LAST_KEEP : FULL_KEEP) : '0;

   // A load always wins over the final chunk leaving, which is what makes back-to-back beats bubble-free.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state    <= EMPTY;
         chunk    <= '0;
         buf_data <= '0;
         buf_last <= 1'b0;
      end else if (load) begin
         state    <= SEND;
         chunk    <= '0;
         buf_data <= s_axis_tdata;
         buf_last <= s_axis_tlast;
      end else if (out_hs) begin
         if (last_chunk) begin
            state <= EMPTY;
            chunk <= '0;
         end else begin
            chunk <= chunk + 1'b1;
         end
      end
   end

`ifdef AXIS_OUTPUT_PIPE_STATS_EN
   always_ff @(posedge aclk) begin
      if (areset) begin
         m_stat_packets <= '0;
         m_stat_stalls  <= '0;
      end else begin
         if (out_hs && m_axis_tlast) begin
            m_stat_packets <= m_stat_packets + 32'd1;
         end
         if (full && !m_axis_tready) begin
            m_stat_stalls <= m_stat_stalls + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_axis_output_pipe.sv
// Directed and randomised bench for axis_output_pipe (ROWS=8, 32-bit words, 96-bit bus).
module tb_axis_output_pipe;

   logic         aclk;
   logic         areset;
   logic         s_axis_tready;
   logic         s_axis_tvalid;
   logic         s_axis_tlast;
   logic [255:0] s_axis_tdata;
   logic         m_axis_tready;
   logic         m_axis_tvalid;
   logic         m_axis_tlast;
   logic [95:0]  m_axis_tdata;
   logic [2:0]   m_axis_tkeep;
`ifdef AXIS_OUTPUT_PIPE_STATS_EN
   logic [31:0]  m_stat_packets;
   logic [31:0]  m_stat_stalls;
`endif

   int errorCount = 0;
   int checkCount = 0;

   axis_output_pipe #(
      .ROWS(8),
      .WORD_WIDTH_OUT(32),
      .M_OUTPUT_WIDTH_LF(96)
   ) dut (
      .aclk(aclk),
      .areset(areset),
      .s_axis_tready(s_axis_tready),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast),
      .s_axis_tdata(s_axis_tdata),
      .m_axis_tready(m_axis_tready),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tlast(m_axis_tlast),
      .m_axis_tdata(m_axis_tdata),
      .m_axis_tkeep(m_axis_tkeep)
`ifdef AXIS_OUTPUT_PIPE_STATS_EN
      ,
      .m_stat_packets(m_stat_packets),
      .m_stat_stalls(m_stat_stalls)
`endif
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic last, input logic [255:0] data, input logic mready);
      s_axis_tvalid = valid;
      s_axis_tlast  = last;
      s_axis_tdata  = data;
      m_axis_tready = mready;
   endtask

   task automatic tick;
      @(posedge aclk);
      #1;
   endtask

   function automatic logic [255:0] seqBeat(input logic [31:0] base);
      logic [255:0] b;
      for (int r = 0; r < 8; r++) b[r*32 +: 32] = base + 32'(r);
      return b;
   endfunction

   // Reference chunk as {tlast, keep, data}: three words per chunk, missing words zero with keep cleared.
   function automatic logic [99:0] expChunk(input logic [255:0] beat, input int c, input logic lastBeat);
      logic [95:0] d;
      logic [2:0]  k;
      d = '0;
      k = '0;
      for (int j = 0; j < 3; j++) begin
         if (c * 3 + j < 8) begin
            d[j*32 +: 32] = beat[(c*3+j)*32 +: 32];
            k[j]          = 1'b1;
         end
      end
      return {lastBeat && (c == 2), k, d};
   endfunction

   function automatic logic [99:0] obsChunk();
      return {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
   endfunction

`ifdef AXIS_OUTPUT_PIPE_STATS_EN
   task automatic sendPacket(input logic [31:0] base, input int stalls);
      applyStimulus(1'b1, 1'b1, seqBeat(base), 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      repeat (stalls) tick();
      m_axis_tready = 1'b1;
      repeat (3) tick();
   endtask
`endif

   initial begin
      logic [99:0]  sbQ[$];
      logic [255:0] rnd;
      logic         sHs;
      int           sent;
      int           cycles;
      int           nextBeat;

      areset = 1'b1;
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      repeat (2) tick();
      @(negedge aclk);
      checkOutput("rst_valid", m_axis_tvalid, 0);
      checkOutput("rst_outputs", obsChunk(), 0);
      checkOutput("rst_s_ready", s_axis_tready, 0);
      tick();
      areset = 1'b0;
      #1;
      checkOutput("rel_s_ready", s_axis_tready, 1);

      // Single engine beat split into three chunks
      applyStimulus(1'b1, 1'b1, seqBeat(32'h10), 1'b1);
      @(negedge aclk);
      checkOutput("single_pre_valid", m_axis_tvalid, 0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      @(negedge aclk);
      checkOutput("single_c0_valid", m_axis_tvalid, 1);
      checkOutput("single_c0", obsChunk(), {1'b0, 3'b111, 32'h12, 32'h11, 32'h10});
      tick();
      @(negedge aclk);
      checkOutput("single_c1", obsChunk(), {1'b0, 3'b111, 32'h15, 32'h14, 32'h13});
      tick();
      @(negedge aclk);
      checkOutput("single_c2", obsChunk(), {1'b1, 3'b011, 32'h0, 32'h17, 32'h16});
      tick();
      @(negedge aclk);
      checkOutput("single_idle", m_axis_tvalid, 0);

      // Four back-to-back beats produce twelve gap-free chunks
      applyStimulus(1'b1, 1'b0, seqBeat(32'h100), 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, seqBeat(32'h200), 1'b1);
      for (int i = 0; i < 12; i++) begin
         @(negedge aclk);
         checkOutput("b2b_valid", m_axis_tvalid, 1);
         checkOutput("b2b_chunk", obsChunk(),
                     expChunk(seqBeat(32'(((i / 3) + 1) * 256)), i % 3, (i / 3) == 3));
         checkOutput("b2b_s_ready", s_axis_tready, (i % 3) == 2);
         tick();
         if ((i % 3) == 2) begin
            nextBeat = i / 3 + 2;
            if (nextBeat < 4) applyStimulus(1'b1, nextBeat == 3, seqBeat(32'((nextBeat + 1) * 256)), 1'b1);
            else              applyStimulus(1'b0, 1'b0, '0, 1'b1);
         end
      end
      @(negedge aclk);
      checkOutput("b2b_idle", m_axis_tvalid, 0);

      // Backpressure for five cycles on chunk 1
      applyStimulus(1'b1, 1'b1, seqBeat(32'h20), 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      @(negedge aclk);
      checkOutput("bp_c0", obsChunk(), {1'b0, 3'b111, 32'h22, 32'h21, 32'h20});
      tick();
      m_axis_tready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge aclk);
         checkOutput("bp_hold_valid", m_axis_tvalid, 1);
         checkOutput("bp_hold_chunk", obsChunk(), {1'b0, 3'b111, 32'h25, 32'h24, 32'h23});
         checkOutput("bp_hold_s_ready", s_axis_tready, 0);
         tick();
      end
      m_axis_tready = 1'b1;
      @(negedge aclk);
      checkOutput("bp_resume_c1", obsChunk(), {1'b0, 3'b111, 32'h25, 32'h24, 32'h23});
      tick();
      @(negedge aclk);
      checkOutput("bp_resume_c2", obsChunk(), {1'b1, 3'b011, 32'h0, 32'h27, 32'h26});
      checkOutput("bp_c2_s_ready", s_axis_tready, 1);
      tick();
      @(negedge aclk);
      checkOutput("bp_idle", m_axis_tvalid, 0);

      // Reset while chunk 1 is on the bus
      applyStimulus(1'b1, 1'b1, seqBeat(32'h40), 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      tick();
      @(negedge aclk);
      checkOutput("mid_c1", obsChunk(), {1'b0, 3'b111, 32'h45, 32'h44, 32'h43});
      areset = 1'b1;
      #1;
      checkOutput("mid_rst_s_ready", s_axis_tready, 0);
      tick();
      @(negedge aclk);
      checkOutput("mid_rst_valid", m_axis_tvalid, 0);
      checkOutput("mid_rst_outputs", obsChunk(), 0);
      areset = 1'b0;
      #1;
      checkOutput("mid_rel_s_ready", s_axis_tready, 1);
      applyStimulus(1'b1, 1'b1, seqBeat(32'h50), 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      @(negedge aclk);
      checkOutput("mid_after_c0", obsChunk(), {1'b0, 3'b111, 32'h52, 32'h51, 32'h50});
      repeat (2) tick();
      @(negedge aclk);
      checkOutput("mid_after_c2", obsChunk(), {1'b1, 3'b011, 32'h0, 32'h57, 32'h56});
      tick();

      // Random valid/ready traffic against a chunk scoreboard
      sent   = 0;
      cycles = 0;
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      while ((sent < 1000 || sbQ.size() != 0 || s_axis_tvalid) && cycles < 20000) begin
         @(negedge aclk);
         cycles++;
         if (m_axis_tvalid && m_axis_tready) begin
            if (sbQ.size() == 0) checkOutput("rand_extra_chunk", 1, 0);
            else                 checkOutput("rand_chunk", obsChunk(), sbQ.pop_front());
         end
         sHs = s_axis_tvalid && s_axis_tready;
         if (sHs) begin
            for (int c = 0; c < 3; c++) sbQ.push_back(expChunk(s_axis_tdata, c, s_axis_tlast));
            sent++;
         end
         tick();
         if (sHs || !s_axis_tvalid) begin
            if (sent < 1000 && $urandom_range(1, 0) == 1) begin
               for (int r = 0; r < 8; r++) rnd[r*32 +: 32] = $urandom;
               s_axis_tdata  = rnd;
               s_axis_tlast  = ($urandom_range(3, 0) == 0);
               s_axis_tvalid = 1'b1;
            end else begin
               s_axis_tvalid = 1'b0;
            end
         end
         m_axis_tready = ($urandom_range(1, 0) == 1);
      end
      checkOutput("rand_finished", cycles < 20000, 1);
      checkOutput("rand_beats", sent, 1000);
      checkOutput("rand_sb_empty", sbQ.size(), 0);

`ifdef AXIS_OUTPUT_PIPE_STATS_EN
      areset = 1'b1;
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      tick();
      areset = 1'b0;
      @(negedge aclk);
      checkOutput("stat_rst_packets", m_stat_packets, 0);
      checkOutput("stat_rst_stalls", m_stat_stalls, 0);
      tick();
      sendPacket(32'h60, 5);
      sendPacket(32'h70, 2);
      sendPacket(32'h80, 0);
      @(negedge aclk);
      checkOutput("stat_packets", m_stat_packets, 3);
      checkOutput("stat_stalls", m_stat_stalls, 7);
`endif

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
